psum_link_net: RTL and testbench

- Parametrised local psum network between PE rows; generalises the fixed 6x8 row-chaining logic of the PE array into a standalone block.
- Per column and per link, it routes each row's opsum either into the ipsum of the row below, through a LINK_DEPTH FIFO, or out to the GON. Row 0 is the bottom; addition flows downward.
- Segmented mode (depthwise) cuts links at segment boundaries and feeds a constant zero ipsum to each segment's top row.
- Sits between the PE grid, GIN(ipsum) and GON(opsum).

---
 rtl/psum_link_net.sv | 184 ++++++++++++++++++
 tb/tb_psum_link_net.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_link_net.sv
// Local psum network: chains PE row opsums into the row below via link FIFOs.
// Optional PSUM_LINK_STATS_EN adds per-link-row saturating stall counters.
module psum_link_net #(
    parameter int NUM_ROWS   = 6,
    parameter int NUM_COLS   = 8,
    parameter int DATA_BITS  = 32,
    parameter int SEG_ROWS   = 3,
    parameter int LINK_DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                set_LN,
    input  logic [NUM_ROWS-2:0]                 LN_config_in,
    input  logic                                set_mode,
    input  logic                                mode_in,
    output logic                                cfg_err,
    output logic                                busy,
    input  logic [NUM_ROWS*NUM_COLS-1:0]           pe_opsum_valid,
    input  logic [NUM_ROWS*NUM_COLS*DATA_BITS-1:0] pe_opsum_data,
    output logic [NUM_ROWS*NUM_COLS-1:0]           pe_opsum_ready,
    output logic [NUM_ROWS*NUM_COLS-1:0]           pe_ipsum_valid,
    output logic [NUM_ROWS*NUM_COLS*DATA_BITS-1:0] pe_ipsum_data,
    input  logic [NUM_ROWS*NUM_COLS-1:0]           pe_ipsum_ready,
    input  logic [NUM_ROWS*NUM_COLS-1:0]           gin_ipsum_valid,
    input  logic [DATA_BITS-1:0]                   gin_ipsum_data,
    output logic [NUM_ROWS*NUM_COLS-1:0]           gin_ipsum_ready,
    output logic [NUM_ROWS*NUM_COLS-1:0]           gon_valid,
    output logic [NUM_ROWS*NUM_COLS*DATA_BITS-1:0] gon_data,
    input  logic [NUM_ROWS*NUM_COLS-1:0]           gon_ready
`ifdef PSUM_LINK_STATS_EN
    ,
    output logic [(NUM_ROWS-1)*16-1:0]          stall_cnt
`endif
);

    localparam int R  = NUM_ROWS;
    localparam int C  = NUM_COLS;
    localparam int D  = DATA_BITS;
    localparam int L  = (R - 1) * C;
    localparam int PW = (LINK_DEPTH > 1) ? $clog2(LINK_DEPTH) : 1;
    localparam int CW = $clog2(LINK_DEPTH + 1);

    logic [R-2:0] ln_cfg;
    logic         mode;
    logic [R-2:0] en;
    logic         cfg_req;
    logic         cfg_acc;

    logic [L-1:0] lk_full;
    logic [L-1:0] lk_empty;
    logic [D-1:0] lk_head [L];

    assign cfg_req = set_LN | set_mode;
    assign cfg_acc = cfg_req & ~busy;
    assign busy    = ~(&lk_empty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ln_cfg  <= '0;
            mode    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_req & busy;
            if (cfg_acc) begin
                if (set_LN)   ln_cfg <= LN_config_in;
                if (set_mode) mode   <= mode_in;
            end
        end
    end

    // Links crossing a segment boundary are cut in segmented mode
    for (genvar r = 0; r < R - 1; r++) begin : g_en
        localparam bit SEG_CUT = ((r + 1) % SEG_ROWS) == 0;
        assign en[r] = ln_cfg[r] & ~(mode & SEG_CUT);
    end

`ifdef PSUM_LINK_STATS_EN
    logic [L-1:0] lk_stall;
`endif

    for (genvar r = 0; r < R - 1; r++) begin : g_lrow
        for (genvar c = 0; c < C; c++) begin : g_lcol
            localparam int K  = r * C + c;
            localparam int UP = (r + 1) * C + c;
            logic [D-1:0]  mem [LINK_DEPTH];
            logic [PW-1:0] wp;
            logic [PW-1:0] rp;
            logic [CW-1:0] cnt;
            logic          full;
            logic          empty;
            logic          push;
            logic          pop;

            assign full  = cnt == CW'(LINK_DEPTH);
            assign empty = cnt == '0;
            assign push  = en[r] & pe_opsum_valid[UP] & ~full;
            assign pop   = en[r] & pe_ipsum_ready[K] & ~empty;

            assign lk_full[K]  = full;
            assign lk_empty[K] = empty;
            assign lk_head[K]  = mem[rp];
`ifdef PSUM_LINK_STATS_EN
            assign lk_stall[K] = en[r] & pe_opsum_valid[UP] & full;
`endif

            always_ff @(posedge clk) begin
                if (push) mem[wp] <= pe_opsum_data[UP*D +: D];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wp  <= '0;
                    rp  <= '0;
                    cnt <= '0;
                end else begin
                    if (push)
                        wp <= (wp == PW'(LINK_DEPTH - 1)) ? '0 : wp + PW'(1);
                    if (pop)
                        rp <= (rp == PW'(LINK_DEPTH - 1)) ? '0 : rp + PW'(1);
                    cnt <= cnt + CW'(push) - CW'(pop);
                end
            end
        end
    end

    for (genvar r = 0; r < R; r++) begin : g_prow
        localparam bit SEG_TOP = (r % SEG_ROWS) == (SEG_ROWS - 1);
        for (genvar c = 0; c < C; c++) begin : g_pcol
            localparam int I = r * C + c;
            logic         link_dn;
            logic         link_up;
            logic         dn_empty;
            logic         up_full;
            logic         zero_src;
            logic [D-1:0] dn_head;

            if (r < R - 1) begin : g_dn
                assign link_dn  = en[r];
                assign dn_empty = lk_empty[I];
                assign dn_head  = lk_head[I];
            end else begin : g_nodn
                assign link_dn  = 1'b0;
                assign dn_empty = 1'b1;
                assign dn_head  = '0;
            end

            if (r > 0) begin : g_up
                assign link_up = en[r-1];
                assign up_full = lk_full[I-C];
            end else begin : g_noup
                assign link_up = 1'b0;
                assign up_full = 1'b0;
            end

            assign zero_src = ~link_dn & mode & SEG_TOP;

            assign pe_ipsum_valid[I] = link_dn  ? ~dn_empty :
                                       zero_src ? 1'b1 : gin_ipsum_valid[I];
            assign pe_ipsum_data[I*D +: D] = link_dn  ? dn_head :
                                             zero_src ? '0 : gin_ipsum_data;
            assign gin_ipsum_ready[I] = ~link_dn & ~zero_src & pe_ipsum_ready[I];

            assign pe_opsum_ready[I]   = link_up ? ~up_full : gon_ready[I];
            assign gon_valid[I]        = ~link_up & pe_opsum_valid[I];
            assign gon_data[I*D +: D]  = pe_opsum_data[I*D +: D];
        end
    end

`ifdef PSUM_LINK_STATS_EN
    for (genvar r = 0; r < R - 1; r++) begin : g_stat
        logic [15:0] sc;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                sc <= '0;
            else if (cfg_acc)
                sc <= '0;
            else if ((|lk_stall[r*C +: C]) && sc != 16'hFFFF)
                sc <= sc + 16'd1;
        end
        assign stall_cnt[r*16 +: 16] = sc;
    end
`endif

endmodule

// File: tb/tb_psum_link_net.sv
// Self-checking bench for psum_link_net with a queue scoreboard on link 1 col 1.
`timescale 1ns/1ps
module tb_psum_link_net;

    localparam int R = 6;
    localparam int C = 8;
    localparam int D = 32;
    localparam int N = R * C;

    logic           clk = 1'b0;
    logic           rst;
    logic           set_LN;
    logic [R-2:0]   LN_config_in;
    logic           set_mode;
    logic           mode_in;
    logic           cfg_err;
    logic           busy;
    logic [N-1:0]   pe_opsum_valid;
    logic [N*D-1:0] pe_opsum_data;
    logic [N-1:0]   pe_opsum_ready;
    logic [N-1:0]   pe_ipsum_valid;
    logic [N*D-1:0] pe_ipsum_data;
    logic [N-1:0]   pe_ipsum_ready;
    logic [N-1:0]   gin_ipsum_valid;
    logic [D-1:0]   gin_ipsum_data;
    logic [N-1:0]   gin_ipsum_ready;
    logic [N-1:0]   gon_valid;
    logic [N*D-1:0] gon_data;
    logic [N-1:0]   gon_ready;
`ifdef PSUM_LINK_STATS_EN
    logic [(R-1)*16-1:0] stall_cnt;
`endif

    int checks = 0;
    int fails  = 0;
    logic [D-1:0] sb [$];

    psum_link_net dut (
        .clk(clk), .rst(rst),
        .set_LN(set_LN), .LN_config_in(LN_config_in),
        .set_mode(set_mode), .mode_in(mode_in),
        .cfg_err(cfg_err), .busy(busy),
        .pe_opsum_valid(pe_opsum_valid), .pe_opsum_data(pe_opsum_data),
        .pe_opsum_ready(pe_opsum_ready),
        .pe_ipsum_valid(pe_ipsum_valid), .pe_ipsum_data(pe_ipsum_data),
        .pe_ipsum_ready(pe_ipsum_ready),
        .gin_ipsum_valid(gin_ipsum_valid), .gin_ipsum_data(gin_ipsum_data),
        .gin_ipsum_ready(gin_ipsum_ready),
        .gon_valid(gon_valid), .gon_data(gon_data), .gon_ready(gon_ready)
`ifdef PSUM_LINK_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [D-1:0] ipd(int i);
        return pe_ipsum_data[i*D +: D];
    endfunction

    function automatic logic [D-1:0] gnd(int i);
        return gon_data[i*D +: D];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [R-2:0] ln, input logic m);
        set_LN = 1'b1; LN_config_in = ln;
        set_mode = 1'b1; mode_in = m;
        tick();
        set_LN = 1'b0; set_mode = 1'b0;
    endtask

    task automatic drain9(input int budget);
        pe_ipsum_ready[9] = 1'b1;
        for (int k = 0; k < budget && sb.size() > 0; k++) begin
            #1;
            if (pe_ipsum_valid[9]) begin
                logic [D-1:0] exp;
                exp = sb.pop_front();
                checks++;
                if (ipd(9) !== exp) begin
                    fails++;
                    $display("FAIL drain9 data got %h exp %h", ipd(9), exp);
                end
            end
            tick();
        end
        checks++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL drain9 left %0d busy %b exp 0 0", sb.size(), busy);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; set_LN = 0; set_mode = 0; LN_config_in = '0; mode_in = 0;
        pe_opsum_valid = '0; pe_opsum_data = '0; pe_ipsum_ready = '0;
        gin_ipsum_valid = '0; gin_ipsum_data = '0; gon_ready = '0;
        tick();
        checks++;
        if (busy !== 1'b0 || cfg_err !== 1'b0) begin
            fails++;
            $display("FAIL reset busy %b cfg_err %b exp 0 0", busy, cfg_err);
        end
        checks++;
        if (pe_ipsum_valid !== '0 || gon_valid !== '0) begin
            fails++;
            $display("FAIL reset valids ip %h gon %h exp 0", pe_ipsum_valid, gon_valid);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_gon_pass();
        pe_opsum_valid[9] = 1'b1;
        pe_opsum_data[9*D +: D] = 32'h1234;
        gon_ready = '1;
        gin_ipsum_valid[1] = 1'b1;
        gin_ipsum_data = 32'hBEEF;
        pe_ipsum_ready[1] = 1'b1;
        #1;
        checks++;
        if (gon_valid[9] !== 1'b1 || gnd(9) !== 32'h1234 || pe_opsum_ready[9] !== 1'b1) begin
            fails++;
            $display("FAIL gon_pass v %b d %h r %b exp 1 1234 1",
                     gon_valid[9], gnd(9), pe_opsum_ready[9]);
        end
        checks++;
        if (pe_ipsum_valid[1] !== 1'b1 || ipd(1) !== 32'hBEEF || gin_ipsum_ready[1] !== 1'b1) begin
            fails++;
            $display("FAIL gin_pass v %b d %h r %b exp 1 beef 1",
                     pe_ipsum_valid[1], ipd(1), gin_ipsum_ready[1]);
        end
        tick();
        pe_opsum_valid = '0; gin_ipsum_valid = '0; pe_ipsum_ready = '0;
    endtask

    task automatic test_link();
        load_cfg(5'b00010, 1'b0);
        pe_ipsum_ready[9] = 1'b1;
        pe_opsum_valid[17] = 1'b1;
        pe_opsum_data[17*D +: D] = 32'hA5;
        #1;
        checks++;
        if (pe_opsum_ready[17] !== 1'b1 || gon_valid[17] !== 1'b0 || pe_ipsum_valid[9] !== 1'b0) begin
            fails++;
            $display("FAIL link_push r %b gon %b ipv %b exp 1 0 0",
                     pe_opsum_ready[17], gon_valid[17], pe_ipsum_valid[9]);
        end
        sb.push_back(32'hA5);
        tick();
        pe_opsum_valid[17] = 1'b0;
        #1;
        checks++;
        if (pe_ipsum_valid[9] !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL link_lat v %b busy %b exp 1 1", pe_ipsum_valid[9], busy);
        end
        drain9(4);
    endtask

    task automatic test_backpressure();
        pe_ipsum_ready[9] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pe_opsum_valid[17] = 1'b1;
            pe_opsum_data[17*D +: D] = 32'h100 + k;
            #1;
            checks++;
            if (pe_opsum_ready[17] !== (k < 2)) begin
                fails++;
                $display("FAIL bp_ready k%0d got %b exp %b", k, pe_opsum_ready[17], k < 2);
            end
            if (k < 2) sb.push_back(32'h100 + k);
            tick();
        end
        pe_opsum_valid[17] = 1'b0;
        drain9(10);
    endtask

    task automatic test_back_to_back();
        int occ = 0;
        for (int k = 0; k < 60; k++) begin
            logic v, rd;
            v  = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            pe_opsum_valid[17] = v;
            pe_opsum_data[17*D +: D] = $urandom;
            pe_ipsum_ready[9] = rd;
            #1;
            checks++;
            if (pe_opsum_ready[17] !== (occ < 2) || pe_ipsum_valid[9] !== (occ > 0)) begin
                fails++;
                $display("FAIL b2b k%0d rdy %b vld %b occ %0d",
                         k, pe_opsum_ready[17], pe_ipsum_valid[9], occ);
            end
            if (rd && occ > 0) begin
                logic [D-1:0] exp;
                exp = sb.pop_front();
                checks++;
                if (ipd(9) !== exp) begin
                    fails++;
                    $display("FAIL b2b data got %h exp %h", ipd(9), exp);
                end
                occ--;
            end
            if (v && (occ + ((rd && pe_ipsum_valid[9]) ? 1 : 0)) < 2) begin
                sb.push_back(pe_opsum_data[17*D +: D]);
                occ++;
            end
            tick();
        end
        pe_opsum_valid[17] = 1'b0;
        drain9(10);
    endtask

    task automatic test_segmented();
        load_cfg(5'b11111, 1'b1);
        gin_ipsum_valid = '0;
        gin_ipsum_data = 32'hDEAD;
        pe_ipsum_ready[16] = 1'b1;
        pe_opsum_valid[24] = 1'b1;
        pe_opsum_data[24*D +: D] = 32'h77;
        pe_opsum_valid[32] = 1'b1;
        pe_opsum_data[32*D +: D] = 32'h88;
        #1;
        checks++;
        if (pe_ipsum_valid[16] !== 1'b1 || ipd(16) !== '0 || gin_ipsum_ready[16] !== 1'b0) begin
            fails++;
            $display("FAIL seg_pe16 v %b d %h gr %b exp 1 0 0",
                     pe_ipsum_valid[16], ipd(16), gin_ipsum_ready[16]);
        end
        checks++;
        if (pe_ipsum_valid[40] !== 1'b1 || ipd(40) !== '0) begin
            fails++;
            $display("FAIL seg_pe40 v %b d %h exp 1 0", pe_ipsum_valid[40], ipd(40));
        end
        checks++;
        if (gon_valid[24] !== 1'b1 || gnd(24) !== 32'h77 || pe_opsum_ready[24] !== 1'b1) begin
            fails++;
            $display("FAIL seg_gon24 v %b d %h r %b exp 1 77 1",
                     gon_valid[24], gnd(24), pe_opsum_ready[24]);
        end
        checks++;
        if (gon_valid[32] !== 1'b0 || pe_opsum_ready[32] !== 1'b1) begin
            fails++;
            $display("FAIL seg_link32 gon %b r %b exp 0 1", gon_valid[32], pe_opsum_ready[32]);
        end
        pe_opsum_valid = '0;
        pe_ipsum_ready = '1;
        tick();
        tick();
        pe_ipsum_ready = '0;
    endtask

    task automatic test_cfg_err();
        load_cfg(5'b00010, 1'b0);
        pe_opsum_valid[17] = 1'b1;
        pe_opsum_data[17*D +: D] = 32'hC0DE;
        sb.push_back(32'hC0DE);
        tick();
        pe_opsum_valid[17] = 1'b0;
        set_LN = 1'b1; LN_config_in = 5'b11111;
        tick();
        set_LN = 1'b0;
        checks++;
        if (cfg_err !== 1'b1) begin
            fails++;
            $display("FAIL cfg_err_pulse got %b exp 1", cfg_err);
        end
        tick();
        checks++;
        if (cfg_err !== 1'b0) begin
            fails++;
            $display("FAIL cfg_err_clear got %b exp 0", cfg_err);
        end
        pe_opsum_valid[25] = 1'b1;
        #1;
        checks++;
        if (gon_valid[25] !== 1'b1) begin
            fails++;
            $display("FAIL cfg_kept gon25 got %b exp 1", gon_valid[25]);
        end
        pe_opsum_valid[25] = 1'b0;
        drain9(6);
        load_cfg(5'b11111, 1'b0);
        pe_opsum_valid[25] = 1'b1;
        #1;
        checks++;
        if (cfg_err !== 1'b0 || gon_valid[25] !== 1'b0) begin
            fails++;
            $display("FAIL cfg_load err %b gon25 %b exp 0 0", cfg_err, gon_valid[25]);
        end
        pe_opsum_valid[25] = 1'b0;
    endtask

    task automatic test_reset_mid();
        load_cfg(5'b00010, 1'b0);
        pe_ipsum_ready = '0;
        for (int k = 0; k < 2; k++) begin
            pe_opsum_valid[17] = 1'b1;
            pe_opsum_data[17*D +: D] = 32'h50 + k;
            tick();
        end
        pe_opsum_valid[17] = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || pe_ipsum_valid[9] !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_pre busy %b v %b exp 1 1", busy, pe_ipsum_valid[9]);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || pe_ipsum_valid !== '0) begin
            fails++;
            $display("FAIL rstmid busy %b ipv %h exp 0 0", busy, pe_ipsum_valid);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_gon_pass();
        test_link();
        test_backpressure();
        test_back_to_back();
        test_segmented();
        test_cfg_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
